// File: rtl/vga_pkg.sv
// Shared VGA pipeline types and constants: timing/colour widths, sprite size,
// the bundle passed between draw stages, and the sprite overlay states.
package vga_pkg;

  localparam int HCNT_W   = 11;
  localparam int VCNT_W   = 11;
  localparam int RGB_W    = 12;
  localparam int POS_W    = 12;

  localparam int SPRITE_W = 32;
  localparam int SPRITE_H = 32;

  localparam logic [RGB_W-1:0] KEY_BLACK = 12'h000;

  typedef struct packed {
    logic [HCNT_W-1:0] hcount;
    logic              hsync;
    logic              hblnk;
    logic [VCNT_W-1:0] vcount;
    logic              vsync;
    logic              vblnk;
    logic [RGB_W-1:0]  rgb;
  } vga_bus_t;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    ACTIVE     = 1'b1
  } sprite_state_e;

endpackage

// File: rtl/vga_delay.sv
// N-stage register delay for the VGA timing bundle plus colour; any draw stage
// that needs its timing re-aligned with a multi-cycle colour path can reuse it.
module vga_delay
  import vga_pkg::*;
#(
  parameter int N = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  vga_bus_t bus_i,
  output vga_bus_t bus_o
);

  vga_bus_t stage_q [N];

  // NOTE: sequential state is written with non-blocking assignments so every
  // stage samples the value its predecessor held before this edge. The array
  // is a short shift register, not a RAM, so it is reset like any other flop
  // to keep the outputs at 0 while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= bus_i;
      for (int i = 1; i < N; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign bus_o = stage_q[N-1];

endmodule

// File: rtl/sprite_draw_32x32.sv
// Overlays a ROM-backed sprite onto the VGA stream: addresses the registered ROM,
// then composites its pixel with the background, 3 clocks of constant latency.
module sprite_draw_32x32
  import vga_pkg::*;
#(
  parameter int               IMG_W   = SPRITE_W,
  parameter int               IMG_H   = SPRITE_H,
  parameter int               ADDR_W  = 10,
  parameter bit               KEY_EN  = 1'b1,
  parameter logic [RGB_W-1:0] KEY_RGB = KEY_BLACK
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [HCNT_W-1:0] hcount_in,
  input  logic              hsync_in,
  input  logic              hblnk_in,
  input  logic [VCNT_W-1:0] vcount_in,
  input  logic              vsync_in,
  input  logic              vblnk_in,
  input  logic [RGB_W-1:0]  rgb_in,
  input  logic [POS_W-1:0]  xpos,
  input  logic [POS_W-1:0]  ypos,
  input  logic [RGB_W-1:0]  rgb_pixel,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic [HCNT_W-1:0] hcount_out,
  output logic              hsync_out,
  output logic              hblnk_out,
  output logic [VCNT_W-1:0] vcount_out,
  output logic              vsync_out,
  output logic              vblnk_out,
  output logic [RGB_W-1:0]  rgb_out
);

  localparam int AX_W  = $clog2(IMG_W);
  localparam int AY_W  = $clog2(IMG_H);
  localparam int CMP_W = POS_W + 1;

  sprite_state_e     state_q, state_d;
  logic              vsync_q;
  logic              vsync_rise;
  logic [POS_W-1:0]  x_lat_q, y_lat_q;
  logic [ADDR_W-1:0] pixel_addr_q, pixel_addr_d;
  logic              in_sprite, in_d1_q, in_d2_q;
  vga_bus_t          bus_s1, bus_d2, out_q, out_d;

  assign vsync_rise = vsync_in & ~vsync_q;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_FRAME: if (vsync_rise) state_d = ACTIVE;
      ACTIVE:     state_d = ACTIVE;
      default:    state_d = WAIT_FRAME;
    endcase
  end

  // Position is sampled only on the vsync edge so a frame never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_FRAME;
      vsync_q <= 1'b0;
      x_lat_q <= '0;
      y_lat_q <= '0;
    end else begin
      state_q <= state_d;
      vsync_q <= vsync_in;
      if (vsync_rise) begin
        x_lat_q <= xpos;
        y_lat_q <= ypos;
      end
    end
  end

  // Stage 1: one bit wider than the position so x+IMG_W clips instead of wrapping.
  logic [CMP_W-1:0] h_ext, v_ext, x_ext, y_ext, x_end, y_end;
  logic [AX_W-1:0]  addr_x;
  logic [AY_W-1:0]  addr_y;

  assign h_ext = CMP_W'(hcount_in);
  assign v_ext = CMP_W'(vcount_in);
  assign x_ext = CMP_W'(x_lat_q);
  assign y_ext = CMP_W'(y_lat_q);
  assign x_end = x_ext + CMP_W'(IMG_W);
  assign y_end = y_ext + CMP_W'(IMG_H);

  assign in_sprite = ~hblnk_in & ~vblnk_in &
                     (h_ext >= x_ext) & (h_ext < x_end) &
                     (v_ext >= y_ext) & (v_ext < y_end);

  assign addr_x       = hcount_in[AX_W-1:0] - x_lat_q[AX_W-1:0];
  assign addr_y       = vcount_in[AY_W-1:0] - y_lat_q[AY_W-1:0];
  assign pixel_addr_d = in_sprite ? ADDR_W'({addr_y, addr_x}) : pixel_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_addr_q <= '0;
      in_d1_q      <= 1'b0;
      in_d2_q      <= 1'b0;
    end else begin
      pixel_addr_q <= pixel_addr_d;
      in_d1_q      <= in_sprite;
      in_d2_q      <= in_d1_q;
    end
  end

  assign pixel_addr = pixel_addr_q;

  assign bus_s1 = '{hcount: hcount_in, hsync: hsync_in, hblnk: hblnk_in,
                    vcount: vcount_in, vsync: vsync_in, vblnk: vblnk_in,
                    rgb: rgb_in};

  vga_delay #(.N(2)) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_i (bus_s1),
    .bus_o (bus_d2)
  );

  // Stage 3: ROM word arrives alongside the twice-delayed background.
  logic key_hit, draw;

  assign key_hit = KEY_EN & (rgb_pixel == KEY_RGB);
  assign draw    = (state_q == ACTIVE) & in_d2_q & ~key_hit;

  always_comb begin
    out_d     = bus_d2;
    out_d.rgb = draw ? rgb_pixel : bus_d2.rgb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= out_d;
  end

  assign hcount_out = out_q.hcount;
  assign hsync_out  = out_q.hsync;
  assign hblnk_out  = out_q.hblnk;
  assign vcount_out = out_q.vcount;
  assign vsync_out  = out_q.vsync;
  assign vblnk_out  = out_q.vblnk;
  assign rgb_out    = out_q.rgb;

endmodule

// File: tb/tb_sprite_draw_32x32.sv
// Self-checking bench: keyed and unkeyed instances fed from a registered ROM
// model; expected outputs queued at drive time and compared 3 clocks later.
module tb_sprite_draw_32x32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic [11:0] rgb_in, xpos, ypos;
  logic [11:0] rgb_pixel, rgb_pixel_nk;
  logic [9:0]  pixel_addr, pixel_addr_nk;
  logic [10:0] hcount_out, vcount_out, hcount_out_nk, vcount_out_nk;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic        hsync_out_nk, hblnk_out_nk, vsync_out_nk, vblnk_out_nk;
  logic [11:0] rgb_out, rgb_out_nk;

  always #5 clk = ~clk;

  sprite_draw_32x32 #(.KEY_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .rgb_pixel(rgb_pixel),
    .pixel_addr(pixel_addr),
    .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  sprite_draw_32x32 #(.KEY_EN(1'b0)) u_dut_nk (
    .clk(clk), .rst_n(rst_n),
    .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .rgb_pixel(rgb_pixel_nk),
    .pixel_addr(pixel_addr_nk),
    .hcount_out(hcount_out_nk), .hsync_out(hsync_out_nk), .hblnk_out(hblnk_out_nk),
    .vcount_out(vcount_out_nk), .vsync_out(vsync_out_nk), .vblnk_out(vblnk_out_nk),
    .rgb_out(rgb_out_nk)
  );

  // ROM contents: word 5 is the transparent key, every other word is nonzero.
  function automatic logic [11:0] rom_word(input logic [9:0] a);
    return (a == 10'd5) ? 12'h000 : {2'b01, a};
  endfunction

  always @(posedge clk) begin
    rgb_pixel    <= rom_word(pixel_addr);
    rgb_pixel_nk <= rom_word(pixel_addr_nk);
  end

  typedef struct {
    logic [25:0] timing;
    logic [11:0] rgb_in;
    logic [11:0] rgb;
    logic [11:0] rgb_nk;
  } exp_t;

  typedef struct {
    logic [10:0] h, v;
    logic        hb, vb;
    logic [11:0] rgb;
    logic [9:0]  addr;
    logic [11:0] exp_rgb, exp_rgb_nk;
  } vec_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          draw_cnt, draw_cnt_nk;
  int          m_x, m_y;
  bit          m_active, m_vs_prev;
  logic [9:0]  m_addr;
  vec_t        vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Drive one pixel, queue its expectation, advance one clock and compare.
  task automatic step(input logic [10:0] h, input logic hs, input logic hb,
                      input logic [10:0] v, input logic vs, input logic vb,
                      input logic [11:0] rgb, input logic [9:0] e_addr,
                      input logic [11:0] e_rgb, input logic [11:0] e_rgb_nk);
    exp_t e;
    hcount_in = h; hsync_in = hs; hblnk_in = hb;
    vcount_in = v; vsync_in = vs; vblnk_in = vb; rgb_in = rgb;
    e.timing = {h, hs, hb, v, vs, vb};
    e.rgb_in = rgb; e.rgb = e_rgb; e.rgb_nk = e_rgb_nk;
    sb_q.push_back(e);
    m_addr = e_addr;
    if (vs && !m_vs_prev) begin
      m_x = int'(xpos); m_y = int'(ypos); m_active = 1'b1;
    end
    m_vs_prev = vs;
    @(posedge clk); #1;
    check("pixel_addr", 64'(pixel_addr), 64'(e_addr));
    check("pixel_addr_nk", 64'(pixel_addr_nk), 64'(e_addr));
    if (sb_q.size() == 3) begin
      e = sb_q.pop_front();
      check("timing_out", 64'({hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out}), 64'(e.timing));
      check("timing_out_nk", 64'({hcount_out_nk, hsync_out_nk, hblnk_out_nk, vcount_out_nk, vsync_out_nk, vblnk_out_nk}), 64'(e.timing));
      check("rgb_out", 64'(rgb_out), 64'(e.rgb));
      check("rgb_out_nk", 64'(rgb_out_nk), 64'(e.rgb_nk));
      if (rgb_out != e.rgb_in)    draw_cnt++;
      if (rgb_out_nk != e.rgb_in) draw_cnt_nk++;
    end
  endtask

  // Pixel whose expectation comes from the behavioural sprite model.
  task automatic pix(input int h, input int v, input bit hs, input bit hb,
                     input bit vs, input bit vb, input logic [11:0] rgb);
    bit          ins;
    logic [9:0]  a;
    logic [11:0] w, er, enk;
    ins = !hb && !vb && h >= m_x && h < m_x + 32 && v >= m_y && v < m_y + 32;
    a   = ins ? 10'((v - m_y) * 32 + (h - m_x)) : m_addr;
    w   = rom_word(a);
    er  = (m_active && ins && w != 12'h000) ? w : rgb;
    enk = (m_active && ins) ? w : rgb;
    step(11'(h), hs, hb, 11'(v), vs, vb, rgb, a, er, enk);
  endtask

  task automatic frame_sync(input logic [11:0] x, input logic [11:0] y);
    xpos = x; ypos = y;
    for (int i = 0; i < 6; i++)
      pix(900 + i, 620, 1'b0, 1'b0, (i >= 1 && i <= 3), 1'b1, 12'($urandom));
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) pix(900, 620, 1'b0, 1'b1, 1'b0, 1'b1, 12'h123);
  endtask

  task automatic reset_cycles(input int n);
    rst_n = 1'b0;
    sb_q.delete();
    for (int i = 0; i < n; i++) begin
      hcount_in = 11'(200 + i); hsync_in = 1'b0; hblnk_in = 1'b0;
      vcount_in = 11'd10; vsync_in = 1'b0; vblnk_in = 1'b0;
      rgb_in = 12'($urandom);
      @(posedge clk); #1;
      check("reset_outputs", 64'({pixel_addr, hcount_out, hsync_out, hblnk_out, vcount_out,
                                  vsync_out, vblnk_out, rgb_out}), 64'd0);
      check("reset_outputs_nk", 64'({pixel_addr_nk, hcount_out_nk, hsync_out_nk, hblnk_out_nk,
                                     vcount_out_nk, vsync_out_nk, vblnk_out_nk, rgb_out_nk}), 64'd0);
    end
    m_active = 1'b0; m_x = 0; m_y = 0; m_addr = '0; m_vs_prev = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    // Hand-derived vectors for sprite at (100,50): addr = (v-50)*32 + (h-100).
    vecs[0]  = '{11'd100, 11'd50, 1'b0, 1'b0, 12'h111, 10'h000, 12'h400, 12'h400};
    vecs[1]  = '{11'd131, 11'd81, 1'b0, 1'b0, 12'h222, 10'h3FF, 12'h7FF, 12'h7FF};
    vecs[2]  = '{11'd99,  11'd50, 1'b0, 1'b0, 12'h333, 10'h3FF, 12'h333, 12'h333};
    vecs[3]  = '{11'd132, 11'd50, 1'b0, 1'b0, 12'h444, 10'h3FF, 12'h444, 12'h444};
    vecs[4]  = '{11'd105, 11'd50, 1'b0, 1'b0, 12'hABC, 10'h005, 12'hABC, 12'h000};
    vecs[5]  = '{11'd110, 11'd52, 1'b0, 1'b0, 12'h555, 10'h04A, 12'h44A, 12'h44A};
    vecs[6]  = '{11'd131, 11'd82, 1'b0, 1'b0, 12'h666, 10'h04A, 12'h666, 12'h666};
    vecs[7]  = '{11'd100, 11'd49, 1'b0, 1'b0, 12'h777, 10'h04A, 12'h777, 12'h777};
    vecs[8]  = '{11'd110, 11'd52, 1'b1, 1'b0, 12'h888, 10'h04A, 12'h888, 12'h888};
    vecs[9]  = '{11'd115, 11'd60, 1'b0, 1'b1, 12'h999, 10'h04A, 12'h999, 12'h999};
    vecs[10] = '{11'd131, 11'd50, 1'b0, 1'b0, 12'hAAA, 10'h01F, 12'h41F, 12'h41F};
    vecs[11] = '{11'd100, 11'd81, 1'b0, 1'b0, 12'hBBB, 10'h3E0, 12'h7E0, 12'h7E0};

    xpos = '0; ypos = '0;
    reset_cycles(5);

    // Before the first vsync edge the sprite is suppressed even at (0,0).
    draw_cnt = 0; draw_cnt_nk = 0;
    for (int h = 0; h <= 40; h++) pix(h, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'hFFF);
    flush();
    check("wait_frame_draws", 64'(draw_cnt), 64'd0);
    check("wait_frame_draws_nk", 64'(draw_cnt_nk), 64'd0);

    frame_sync(12'd100, 12'd50);
    for (int i = 0; i < 12; i++)
      step(vecs[i].h, 1'b0, vecs[i].hb, vecs[i].v, 1'b0, vecs[i].vb, vecs[i].rgb,
           vecs[i].addr, vecs[i].exp_rgb, vecs[i].exp_rgb_nk);

    // Position change mid-frame takes effect only after the next vsync edge.
    for (int v = 50; v <= 70; v++)
      for (int h = 96; h <= 135; h++) begin
        if (v == 60 && h == 96) xpos = 12'd300;
        pix(h, v, 1'b0, 1'b0, 1'b0, 1'b0, {v[3:0], h[7:0]});
      end
    frame_sync(12'd300, 12'd50);
    for (int v = 50; v <= 53; v++) begin
      for (int h = 96; h <= 135; h++)  pix(h, v, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0);
      for (int h = 296; h <= 335; h++) pix(h, v, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0);
    end

    // Right/bottom clipping on 800x600: 10x10 visible, addr 5 keyed on u_dut.
    frame_sync(12'd790, 12'd590);
    draw_cnt = 0; draw_cnt_nk = 0;
    for (int v = 588; v <= 601; v++) begin
      for (int h = 0; h <= 30; h++)
        pix(h, v, 1'b0, 1'b0, 1'b0, (v >= 600), 12'hFFF);
      for (int h = 780; h <= 830; h++)
        pix(h, v, (h >= 816), (h >= 800), 1'b0, (v >= 600), 12'hFFF);
    end
    flush();
    check("clip_draws", 64'(draw_cnt), 64'd99);
    check("clip_draws_nk", 64'(draw_cnt_nk), 64'd100);

    // Sprite beyond the counter range must never wrap to x=0.
    frame_sync(12'd4090, 12'd590);
    draw_cnt = 0; draw_cnt_nk = 0;
    for (int v = 590; v <= 595; v++)
      for (int h = 0; h <= 40; h++) pix(h, v, 1'b0, 1'b0, 1'b0, 1'b0, 12'hFFF);
    flush();
    check("nowrap_draws", 64'(draw_cnt), 64'd0);
    check("nowrap_draws_nk", 64'(draw_cnt_nk), 64'd0);

    // Reset mid-line returns to WAIT_FRAME until the next vsync edge.
    frame_sync(12'd0, 12'd0);
    for (int h = 0; h < 10; h++) pix(h, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'hFFF);
    reset_cycles(4);
    draw_cnt = 0; draw_cnt_nk = 0;
    for (int h = 10; h <= 40; h++) pix(h, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'hFFF);
    flush();
    check("post_reset_draws", 64'(draw_cnt), 64'd0);
    frame_sync(12'd0, 12'd0);
    draw_cnt = 0; draw_cnt_nk = 0;
    for (int h = 0; h < 32; h++) pix(h, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'hFFF);
    flush();
    check("resync_draws", 64'(draw_cnt), 64'd31);
    check("resync_draws_nk", 64'(draw_cnt_nk), 64'd32);

    // Random timing stream over two frames, compared every cycle.
    for (int f = 0; f < 2; f++) begin
      frame_sync(12'($urandom_range(0, 200)), 12'($urandom_range(0, 100)));
      for (int i = 0; i < 1500; i++)
        pix($urandom_range(0, 255), $urandom_range(0, 127), 1'($urandom),
            ($urandom_range(0, 3) == 0), 1'b0, ($urandom_range(0, 7) == 0),
            12'($urandom));
    end
    flush();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
